exp_lut_pipe: RTL and testbench

//  Inverse of the zonal-backlight log stage: converts a log2-domain brightness value back to an 8-bit gray/PWM level.

---
 rtl/exp_lut_pipe.sv | 136 +++++++++++++
 tb/tb_exp_lut_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_lut_pipe.sv
// Log2-domain to linear gray converter: 2^x via a 17-entry LUT with linear
// interpolation, integer shift, rounding and saturation, in a 3-stage valid/ready pipe.
module exp_lut_pipe #(
   parameter int INT_W    = 4,
   parameter int FRAC_W   = 12,
   parameter int LUT_BITS = 4,
   parameter int TAG_W    = 8,
   parameter int OUT_W    = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [INT_W+FRAC_W-1:0] log_in,
   input  logic [TAG_W-1:0]        in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_W-1:0]        gray_out,
   output logic [TAG_W-1:0]        out_tag
);

   localparam int F_W = FRAC_W - LUT_BITS;

   // T[k] = round(2^(k/16) * 32768); entry 16 closes the last interpolation span.
   function automatic logic [16:0] exp_table(input logic [LUT_BITS:0] idx);
      logic [16:0] t;
      case (idx)
         5'd0:    t = 17'd32768;
         5'd1:    t = 17'd34219;
         5'd2:    t = 17'd35734;
         5'd3:    t = 17'd37316;
         5'd4:    t = 17'd38968;
         5'd5:    t = 17'd40693;
         5'd6:    t = 17'd42495;
         5'd7:    t = 17'd44376;
         5'd8:    t = 17'd46341;
         5'd9:    t = 17'd48393;
         5'd10:   t = 17'd50535;
         5'd11:   t = 17'd52773;
         5'd12:   t = 17'd55109;
         5'd13:   t = 17'd57549;
         5'd14:   t = 17'd60097;
         5'd15:   t = 17'd62757;
         default: t = 17'd65536;
      endcase
      return t;
   endfunction

   logic                adv;
   logic                s1_valid;
   logic [INT_W-1:0]    s1_ip;
   logic [LUT_BITS-1:0] s1_k;
   logic [F_W-1:0]      s1_f;
   logic [TAG_W-1:0]    s1_tag;
   logic                s2_valid;
   logic [INT_W-1:0]    s2_ip;
   logic [16:0]         s2_m;
   logic [TAG_W-1:0]    s2_tag;

   logic [16:0] t_lo;
   logic [16:0] t_hi;
   logic [16:0] t_diff;
   logic [24:0] prod;
   logic [16:0] interp;
   logic [16:0] m_next;
   logic [23:0] v;
   logic [8:0]  g;
   logic [OUT_W-1:0] gray_next;

   // The whole pipe moves as one: it stalls only when the output register is
   // occupied and not being taken, so bubbles never block a later sample.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_ip    <= '0;
         s1_k     <= '0;
         s1_f     <= '0;
         s1_tag   <= '0;
      end else if (adv) begin
         s1_valid <= in_valid;
         s1_ip    <= log_in[FRAC_W +: INT_W];
         s1_k     <= log_in[FRAC_W-1 -: LUT_BITS];
         s1_f     <= log_in[F_W-1:0];
         s1_tag   <= in_tag;
      end
   end

   always_comb begin
      t_lo   = exp_table({1'b0, s1_k});
      t_hi   = exp_table({1'b0, s1_k} + 5'd1);
      t_diff = t_hi - t_lo;
      prod   = {8'b0, t_diff} * {17'b0, s1_f};
      interp = 17'(prod >> F_W);
      m_next = t_lo + interp;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_ip    <= '0;
         s2_m     <= '0;
         s2_tag   <= '0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         s2_ip    <= s1_ip;
         s2_m     <= m_next;
         s2_tag   <= s1_tag;
      end
   end

   // Mantissa is Q1.15, so after the shift adding 2^14 and dropping 15 bits rounds to nearest.
   always_comb begin
      v         = ({7'b0, s2_m} << s2_ip) + 24'd16384;
      g         = 9'(v >> 15);
      gray_next = '1;
      if (s2_ip < INT_W'(8) && !g[8]) begin
         gray_next = g[OUT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         gray_out  <= '0;
         out_tag   <= '0;
      end else if (adv) begin
         out_valid <= s2_valid;
         gray_out  <= gray_next;
         out_tag   <= s2_tag;
      end
   end

endmodule

// File: tb/tb_exp_lut_pipe.sv
// Bench for exp_lut_pipe: directed points, streaming, stall, mid-run reset and a
// randomized scoreboard run against an arithmetic model of 2^x.
module tb_exp_lut_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] log_in;
   logic [7:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  gray_out;
   logic [7:0]  out_tag;

   int errors = 0;
   int checks = 0;
   int lut [17];

   always #5 clk = ~clk;

   exp_lut_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .log_in    (log_in),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .gray_out  (gray_out),
      .out_tag   (out_tag)
   );

   // Reference: table from real-valued 2^(k/16), then interpolate, scale, round, saturate.
   function automatic int model_gray(int x);
      int ip, k, f, m, g;
      ip = x / 4096;
      k  = (x / 256) % 16;
      f  = x % 256;
      if (ip >= 8) return 255;
      m = lut[k] + ((lut[k+1] - lut[k]) * f) / 256;
      g = (m * (2 ** ip) + 16384) / 32768;
      return (g > 255) ? 255 : g;
   endfunction

   task automatic test_reset();
      in_valid = 1'b0; out_ready = 1'b1; log_in = '0; in_tag = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (gray_out !== 8'd0) begin errors++; $display("[TB] FAIL reset_gray: got %0d want 0", gray_out); end
      checks++; if (out_tag !== 8'd0) begin errors++; $display("[TB] FAIL reset_tag: got %0d want 0", out_tag); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
      rst = 1'b0;
      @(posedge clk); #1;
      log_in = 16'h0000; in_tag = 8'h05; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_early: out_valid got %b want 0", out_valid); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || gray_out !== 8'd1 || out_tag !== 8'h05) begin
         errors++;
         $display("[TB] FAIL first_result: got v=%b g=%0d t=%0h want v=1 g=1 t=05", out_valid, gray_out, out_tag);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_points();
      logic [15:0] pts [7];
      int          want [7];
      int          sent = 0, got = 0, cyc = 0;
      bit          acc;
      pts  = '{16'h0000, 16'h7000, 16'h3800, 16'h1800, 16'h7FFF, 16'h8000, 16'hFFFF};
      want = '{1, 128, 11, 3, 255, 255, 255};
      out_ready = 1'b1; in_valid = 1'b0;
      while (got < 7 && cyc < 60) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            checks++;
            if (gray_out !== 8'(want[got]) || out_tag !== 8'(got)) begin
               errors++;
               $display("[TB] FAIL point_%0h: got g=%0d t=%0d want g=%0d t=%0d", pts[got], gray_out, out_tag, want[got], got);
            end
            got++;
         end
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) sent++;
         if (sent < 7) begin in_valid = 1'b1; log_in = pts[sent]; in_tag = 8'(sent); end
         else in_valid = 1'b0;
         cyc++;
      end
      in_valid = 1'b0;
      checks++; if (got != 7) begin errors++; $display("[TB] FAIL points_count: got %0d want 7", got); end
   endtask

   task automatic test_stream();
      int exp_g [$];
      int exp_c [$];
      int sent = 0, got = 0, cyc = 0, eg, ec;
      bit acc;
      out_ready = 1'b1; in_valid = 1'b0;
      while (got < 128 && cyc < 300) begin
         @(negedge clk);
         if (sent > 0 && sent < 128) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_in_ready: got %b want 1", in_ready); end
         end
         if (out_valid && out_ready) begin
            eg = exp_g.pop_front(); ec = exp_c.pop_front();
            checks++;
            if (gray_out !== 8'(eg) || out_tag !== 8'(got) || cyc - ec != 3) begin
               errors++;
               $display("[TB] FAIL stream_%0d: got g=%0d t=%0d lat=%0d want g=%0d t=%0d lat=3", got, gray_out, out_tag, cyc - ec, eg, got & 255);
            end
            got++;
         end
         acc = in_valid && in_ready;
         if (acc) begin exp_g.push_back(model_gray(int'(log_in))); exp_c.push_back(cyc); end
         @(posedge clk); #1;
         if (acc) sent++;
         if (sent < 128) begin in_valid = 1'b1; log_in = 16'(sent * 256); in_tag = 8'(sent); end
         else in_valid = 1'b0;
         cyc++;
      end
      in_valid = 1'b0;
      checks++; if (got != 128) begin errors++; $display("[TB] FAIL stream_count: got %0d want 128", got); end
   endtask

   task automatic test_back_to_back_stall();
      logic [15:0] vals [4];
      int          exp_g [$];
      int          exp_t [$];
      int          acc_cnt = 0, got = 0, eg, et;
      bit          acc;
      vals = '{16'h2345, 16'h5A5A, 16'h6FF0, 16'h0C80};
      out_ready = 1'b0; in_valid = 1'b1; log_in = vals[0]; in_tag = 8'h10;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         @(negedge clk);
         if (cyc == 5) begin
            checks++;
            if (acc_cnt != 3 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
               errors++;
               $display("[TB] FAIL stall_full: got acc=%0d in_ready=%b out_valid=%b want acc=3 in_ready=0 out_valid=1", acc_cnt, in_ready, out_valid);
            end
         end
         if (out_valid && out_ready) begin
            eg = exp_g.pop_front(); et = exp_t.pop_front();
            checks++;
            if (gray_out !== 8'(eg) || out_tag !== 8'(et)) begin
               errors++;
               $display("[TB] FAIL stall_out_%0d: got g=%0d t=%0h want g=%0d t=%0h", got, gray_out, out_tag, eg, et);
            end
            got++;
         end
         acc = in_valid && in_ready;
         if (acc) begin exp_g.push_back(model_gray(int'(log_in))); exp_t.push_back(int'(in_tag)); acc_cnt++; end
         @(posedge clk); #1;
         if (acc) begin
            if (acc_cnt < 4) begin log_in = vals[acc_cnt]; in_tag = 8'(16 + acc_cnt); end
            else in_valid = 1'b0;
         end
         if (cyc >= 5) out_ready = 1'b1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (got != 4) begin errors++; $display("[TB] FAIL stall_count: got %0d want 4", got); end
   endtask

   task automatic test_mid_reset();
      int n = 0;
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         log_in = 16'h7000; in_tag = 8'(i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_valid: got %b want 1", out_valid); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || gray_out !== 8'd0 || out_tag !== 8'd0) begin
         errors++;
         $display("[TB] FAIL async_reset: got v=%b g=%0d t=%0d want all 0", out_valid, gray_out, out_tag);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      log_in = 16'h3800; in_tag = 8'hAA; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) begin
            n++;
            if (n == 1) begin
               checks++;
               if (gray_out !== 8'd11 || out_tag !== 8'hAA) begin
                  errors++;
                  $display("[TB] FAIL post_reset_first: got g=%0d t=%0h want g=11 t=aa", gray_out, out_tag);
               end
            end
         end
      end
      checks++; if (n != 1) begin errors++; $display("[TB] FAIL post_reset_count: got %0d want 1", n); end
   endtask

   task automatic test_random();
      int          exp_g [$];
      int          exp_t [$];
      int          sent = 0, got = 0, cyc = 0, eg, et;
      bit          acc, dlv, prev_stall = 1'b0;
      logic [7:0]  prev_g = '0, prev_t = '0;
      const int    N = 10000;
      in_valid = 1'b0; out_ready = 1'b0;
      while ((sent < N || got < sent) && cyc < 80000) begin
         @(negedge clk);
         checks++;
         if (in_ready !== (!out_valid || out_ready)) begin
            errors++;
            $display("[TB] FAIL rand_in_ready: got %b want %b", in_ready, !out_valid || out_ready);
         end
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || gray_out !== prev_g || out_tag !== prev_t) begin
               errors++;
               $display("[TB] FAIL rand_hold: got v=%b g=%0d t=%0h want v=1 g=%0d t=%0h", out_valid, gray_out, out_tag, prev_g, prev_t);
            end
         end
         dlv = out_valid && out_ready;
         acc = in_valid && in_ready;
         if (dlv) begin
            checks++;
            if (exp_g.size() == 0) begin
               errors++;
               $display("[TB] FAIL rand_spurious: got g=%0d t=%0h want nothing", gray_out, out_tag);
            end else begin
               eg = exp_g.pop_front(); et = exp_t.pop_front();
               if (gray_out !== 8'(eg) || out_tag !== 8'(et)) begin
                  errors++;
                  $display("[TB] FAIL rand_out_%0d: got g=%0d t=%0h want g=%0d t=%0h", got, gray_out, out_tag, eg, et);
               end
            end
            got++;
         end
         if (acc) begin exp_g.push_back(model_gray(int'(log_in))); exp_t.push_back(int'(in_tag)); sent++; end
         prev_stall = out_valid && !out_ready;
         prev_g = gray_out; prev_t = out_tag;
         @(posedge clk); #1;
         if (acc || !in_valid) begin
            in_valid = (sent < N) && ($urandom % 2 == 1);
            log_in   = ($urandom % 4 == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 32767));
            in_tag   = 8'($urandom_range(0, 255));
         end
         out_ready = 1'($urandom % 2);
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (got != N) begin errors++; $display("[TB] FAIL rand_count: got %0d want %0d", got, N); end
   endtask

   initial begin
      for (int k = 0; k < 17; k++) lut[k] = $rtoi((2.0 ** (real'(k) / 16.0)) * 32768.0 + 0.5);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; log_in = '0; in_tag = '0;
      test_reset();
      test_points();
      test_stream();
      test_back_to_back_stall();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
